bcd_to_binary_seq: RTL and testbench

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

---
 rtl/bcd_to_binary_seq.sv | 110 +++++++++++
 tb/tb_bcd_to_binary_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per cycle.
// Optional invalid-digit checking is compiled in with `define BCD_ERRCHK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for start; only state that accepts it
// S_SHIFT  | shifting digits into the binary register
// S_FINISH | one-cycle result-valid pulse (done=1)
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  localparam int BIN_W = $clog2(10 ** DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]          state;
  logic [4*DIGITS-1:0] dig_q;
  logic [BIN_W-1:0]    bin_q;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] dig_sh;
  logic [BIN_W-1:0]    bin_sh;

  // One reverse double-dabble step: halve the whole value, then undo the +3 bias per digit.
  always_comb begin
    {dig_sh, bin_sh} = {dig_q, bin_q} >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_sh[4*d+3])
        dig_sh[4*d +: 4] = dig_sh[4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_ERRCHK_EN
  logic err_q;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dig_q      <= '0;
      bin_q      <= '0;
      cnt        <= '0;
      binary_out <= '0;
`ifdef BCD_ERRCHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dig_q <= bcd_in;
            bin_q <= '0;
            cnt   <= CNT_W'(BIN_W);
`ifdef BCD_ERRCHK_EN
            err_q <= bad_digit;
            if (bad_digit) begin
              binary_out <= '0;
              state      <= S_FINISH;
            end else begin
              state <= S_SHIFT;
            end
`else
            state <= S_SHIFT;
`endif
          end
        end
        S_SHIFT: begin
          dig_q <= dig_sh;
          bin_q <= bin_sh;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            binary_out <= bin_sh;
            state      <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=4).
// Error-path checks follow whichever way BCD_ERRCHK_EN is set for the build.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic [13:0] binary_out;
  logic        busy;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  bcd_to_binary_seq #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .binary_out (binary_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept edge E0, then count edges until done; n=14 means done follows E14.
  task automatic conv(input logic [15:0] v, output int n);
    start  = 1'b1;
    bcd_in = v;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int ndone;
    int idx0;
    int idx1;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) tick();
    chk("reset_out",   binary_out, 0);
    chk("reset_busy",  busy,  0);
    chk("reset_done",  done,  0);
    chk("reset_error", error, 0);

    // start on the very first edge after reset release
    rst_n = 1'b1;
    conv(16'h0000, n);
    chk("zero_lat", n, 14);
    chk("zero_out", binary_out, 0);
    chk("zero_err", error, 0);
    chk("zero_busy_fin", busy, 1);
    tick();
    chk("zero_idle_done", done, 0);
    chk("zero_idle_busy", busy, 0);

    conv(16'h9999, n);
    chk("max_lat", n, 14);
    chk("max_out", binary_out, 9999);
    tick();

    // second start mid-conversion must be ignored
    start  = 1'b1;
    bcd_in = 16'h0255;
    tick();
    start = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    start  = 1'b1;
    bcd_in = 16'h1234;
    tick();
    n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    chk("ign_lat", n, 14);
    chk("ign_out", binary_out, 255);
    // start presented during FINISH is also ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin_start_ignored", busy, 0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("ign_extra_done", ndone, 0);
    chk("ign_out_hold", binary_out, 255);

    // asynchronous reset aborts a conversion
    start  = 1'b1;
    bcd_in = 16'h4321;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out",  binary_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err",  error, 0);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    conv(16'h0042, n);
    chk("post_abort_lat", n, 14);
    chk("post_abort_out", binary_out, 42);
    tick();

`ifdef BCD_ERRCHK_EN
    conv(16'h12A4, n);
    chk("bad_lat", n, 0);
    chk("bad_err", error, 1);
    chk("bad_out", binary_out, 0);
    tick();
    chk("bad_idle", busy, 0);
    conv(16'h1234, n);
    chk("good_lat", n, 14);
    chk("good_err", error, 0);
    chk("good_out", binary_out, 1234);
    tick();
`else
    conv(16'h12A4, n);
    chk("nochk_lat", n, 14);
    chk("nochk_err", error, 0);
    tick();
    conv(16'h1234, n);
    chk("good_lat", n, 14);
    chk("good_err", error, 0);
    chk("good_out", binary_out, 1234);
    tick();
`endif

    // start held high: re-triggers every BIN_W+2 cycles
    start  = 1'b1;
    bcd_in = 16'h0100;
    ndone = 0;
    idx0 = -1;
    idx1 = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        if (ndone == 0) idx0 = i;
        if (ndone == 1) idx1 = i;
        ndone++;
        chk("held_out", binary_out, 100);
      end
    end
    start = 1'b0;
    chk("held_ndone", ndone, 2);
    chk("held_idx0", idx0, 14);
    chk("held_idx1", idx1, 30);
    n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(); n++; end
    chk("held_drain_idle", busy, 0);
    chk("held_final_out", binary_out, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
